// File: rtl/wheel_pwm_pkg.sv
// Shared definitions for the wheel PWM driver: widths, duty scaling, channel
// state encoding and the magnitude-to-duty saturation used by every channel.
// Inputs are signed Q(17-8).8 speeds; the Q scaling is folded into DUTY_SHIFT.
package wheel_pwm_pkg;

  localparam int unsigned N_WIDTH          = 17;
  localparam int unsigned PWM_BITS         = 10;
  localparam int unsigned DUTY_SHIFT       = 6;
  localparam int unsigned DEADTIME_PERIODS = 2;

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  typedef enum logic {
    ST_RUN,
    ST_DEAD
  } chan_state_e;

  // Scale an unsigned speed magnitude to a PWM duty, clamped to DUTY_MAX.
  function automatic logic [PWM_BITS-1:0] sat_duty(input logic [N_WIDTH-1:0] mag);
    logic [N_WIDTH-1:0] shifted;
    shifted = mag >> DUTY_SHIFT;
    if (shifted > N_WIDTH'(DUTY_MAX)) begin
      return DUTY_MAX;
    end
    return shifted[PWM_BITS-1:0];
  endfunction

endpackage

// File: rtl/wheel_pwm_channel.sv
// One wheel channel: samples its speed command at period boundaries, converts
// it to duty/direction, inserts dead-time on reversals and drives the PWM pin.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   cnt_i          shared PWM counter value of the current cycle
//   boundary_i     high in the cycle where cnt_i == DUTY_MAX
//   enable_i       0 -> zero duty for the next period
//   w_i            signed wheel speed command
//   pwm_o, dir_o   registered PWM and direction (1 = forward)
module wheel_pwm_channel
  import wheel_pwm_pkg::*;
#(
  parameter int unsigned DEADTIME_PERIODS = wheel_pwm_pkg::DEADTIME_PERIODS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [PWM_BITS-1:0]        cnt_i,
  input  logic                       boundary_i,
  input  logic                       enable_i,
  input  logic signed [N_WIDTH-1:0]  w_i,
  output logic                       pwm_o,
  output logic                       dir_o
);

  localparam int unsigned DEAD_W = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME_PERIODS - 1);

  chan_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic                dir_q, dir_d;
  logic                pwm_q, pwm_d;

  logic [N_WIDTH-1:0]  w_u_c;
  logic [N_WIDTH-1:0]  mag_c;
  logic                sign_new_c;
  logic [PWM_BITS-1:0] duty_new_c;
  logic [PWM_BITS-1:0] cnt_nxt_c;

  // Magnitude as unsigned: the most negative input maps to 2^(N-1) without overflow.
  assign w_u_c      = $unsigned(w_i);
  assign mag_c      = w_i[N_WIDTH-1] ? (~w_u_c + N_WIDTH'(1)) : w_u_c;
  assign sign_new_c = ~w_i[N_WIDTH-1];
  assign duty_new_c = enable_i ? sat_duty(mag_c) : '0;
  assign cnt_nxt_c  = cnt_i + PWM_BITS'(1);

  // Next state; the PWM bit is precomputed for the counter value of the next cycle
  // so a new duty is visible exactly from the cycle where cnt == 0.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    dir_d   = dir_q;
    if (boundary_i) begin
      case (state_q)
        ST_RUN: begin
          if (duty_new_c == '0) begin
            duty_d = '0;
          end else if (sign_new_c == dir_q) begin
            duty_d = duty_new_c;
          end else begin
            duty_d  = '0;
            dead_d  = DEAD_LOAD;
            state_d = ST_DEAD;
          end
        end
        ST_DEAD: begin
          duty_d = '0;
          if (dead_q != '0) begin
            dead_d = dead_q - DEAD_W'(1);
          end else begin
            dir_d   = sign_new_c;
            duty_d  = duty_new_c;
            state_d = ST_RUN;
          end
        end
      endcase
    end
    pwm_d = (cnt_nxt_c < duty_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      duty_q  <= '0;
      dead_q  <= '0;
      dir_q   <= 1'b1;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
  assign dir_o = dir_q;

endmodule

// File: rtl/wheel_pwm_driver.sv
// Four-wheel PWM driver: shared free-running PWM counter, period pulse and
// four independent channels with boundary-only updates and reversal dead-time.
// Ports:
//   WHEEL_PWM_DRIVER_CLOCK_50       system clock
//   WHEEL_PWM_DRIVER_RESET_InHigh   synchronous active-high reset
//   WHEEL_PWM_DRIVER_ENABLE_In      0 -> all duties 0 from the next boundary
//   WHEEL_PWM_DRIVER_W1..W4_InBus   signed wheel speed commands
//   WHEEL_PWM_DRIVER_PWM1..4_Out    PWM to the bridge enables
//   WHEEL_PWM_DRIVER_DIR1..4_Out    1 = forward, 0 = reverse
//   WHEEL_PWM_DRIVER_PERIOD_Out     1-cycle pulse in the cycle where cnt == 0
module wheel_pwm_driver
  import wheel_pwm_pkg::*;
#(
  parameter int unsigned DEADTIME_PERIODS = wheel_pwm_pkg::DEADTIME_PERIODS
) (
  input  logic                      WHEEL_PWM_DRIVER_CLOCK_50,
  input  logic                      WHEEL_PWM_DRIVER_RESET_InHigh,
  input  logic                      WHEEL_PWM_DRIVER_ENABLE_In,
  input  logic signed [N_WIDTH-1:0] WHEEL_PWM_DRIVER_W1_InBus,
  input  logic signed [N_WIDTH-1:0] WHEEL_PWM_DRIVER_W2_InBus,
  input  logic signed [N_WIDTH-1:0] WHEEL_PWM_DRIVER_W3_InBus,
  input  logic signed [N_WIDTH-1:0] WHEEL_PWM_DRIVER_W4_InBus,
  output logic                      WHEEL_PWM_DRIVER_PWM1_Out,
  output logic                      WHEEL_PWM_DRIVER_PWM2_Out,
  output logic                      WHEEL_PWM_DRIVER_PWM3_Out,
  output logic                      WHEEL_PWM_DRIVER_PWM4_Out,
  output logic                      WHEEL_PWM_DRIVER_DIR1_Out,
  output logic                      WHEEL_PWM_DRIVER_DIR2_Out,
  output logic                      WHEEL_PWM_DRIVER_DIR3_Out,
  output logic                      WHEEL_PWM_DRIVER_DIR4_Out,
  output logic                      WHEEL_PWM_DRIVER_PERIOD_Out
);

  logic                clk;
  logic                rst;
  logic [PWM_BITS-1:0] cnt_q;
  logic                period_q;
  logic                boundary_c;

  assign clk        = WHEEL_PWM_DRIVER_CLOCK_50;
  assign rst        = WHEEL_PWM_DRIVER_RESET_InHigh;
  assign boundary_c = (cnt_q == DUTY_MAX);

  // Counter resets to DUTY_MAX so the first cycle after reset is a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= DUTY_MAX;
      period_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_q + PWM_BITS'(1);
      period_q <= boundary_c;
    end
  end

  assign WHEEL_PWM_DRIVER_PERIOD_Out = period_q;

  wheel_pwm_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS)) u_ch1 (
    .clk_i(clk), .rst_i(rst), .cnt_i(cnt_q), .boundary_i(boundary_c),
    .enable_i(WHEEL_PWM_DRIVER_ENABLE_In), .w_i(WHEEL_PWM_DRIVER_W1_InBus),
    .pwm_o(WHEEL_PWM_DRIVER_PWM1_Out), .dir_o(WHEEL_PWM_DRIVER_DIR1_Out)
  );

  wheel_pwm_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS)) u_ch2 (
    .clk_i(clk), .rst_i(rst), .cnt_i(cnt_q), .boundary_i(boundary_c),
    .enable_i(WHEEL_PWM_DRIVER_ENABLE_In), .w_i(WHEEL_PWM_DRIVER_W2_InBus),
    .pwm_o(WHEEL_PWM_DRIVER_PWM2_Out), .dir_o(WHEEL_PWM_DRIVER_DIR2_Out)
  );

  wheel_pwm_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS)) u_ch3 (
    .clk_i(clk), .rst_i(rst), .cnt_i(cnt_q), .boundary_i(boundary_c),
    .enable_i(WHEEL_PWM_DRIVER_ENABLE_In), .w_i(WHEEL_PWM_DRIVER_W3_InBus),
    .pwm_o(WHEEL_PWM_DRIVER_PWM3_Out), .dir_o(WHEEL_PWM_DRIVER_DIR3_Out)
  );

  wheel_pwm_channel #(.DEADTIME_PERIODS(DEADTIME_PERIODS)) u_ch4 (
    .clk_i(clk), .rst_i(rst), .cnt_i(cnt_q), .boundary_i(boundary_c),
    .enable_i(WHEEL_PWM_DRIVER_ENABLE_In), .w_i(WHEEL_PWM_DRIVER_W4_InBus),
    .pwm_o(WHEEL_PWM_DRIVER_PWM4_Out), .dir_o(WHEEL_PWM_DRIVER_DIR4_Out)
  );

endmodule
